// File: rtl/present_key_sched.sv
// -----------------------------------------------------------------------------
// present_key_sched
//
// PRESENT block-cipher key schedule. A master key is loaded on an accepted
// start and the block then streams NUM_ROUNDS 64-bit round keys over a
// valid/ready handshake, computing the next key register value each time the
// consumer accepts a key. Supports 80-bit and 128-bit PRESENT keys.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst       in   1         asynchronous active-high reset
//   start     in   1         begin a schedule from key_in (honoured in IDLE only)
//   key_in    in   KEY_SIZE  master key, sampled when start is accepted
//   busy      out  1         a schedule is in progress
//   rk_valid  out  1         rk / rk_idx / rk_last are valid
//   rk_ready  in   1         consumer accepts the current round key
//   rk        out  64        current round key (top 64 bits of key register)
//   rk_idx    out  6         round key index, 1..NUM_ROUNDS
//   rk_last   out  1         current key is the final one (index NUM_ROUNDS)
// -----------------------------------------------------------------------------
module present_key_sched #(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [63:0]         rk,
  output logic [5:0]          rk_idx,
  output logic                rk_last
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS);
  // Position of the 5-bit round-counter XOR field in the rotated key.
  localparam int         XOR_LO   = (KEY_SIZE == 128) ? 62 : 15;

  // Reject illegal parameterisations at elaboration time.
  generate
    if ((KEY_SIZE != 80) && (KEY_SIZE != 128)) begin : g_bad_key_size
      $error("present_key_sched: KEY_SIZE must be 80 or 128");
    end
    if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 32)) begin : g_bad_num_rounds
      $error("present_key_sched: NUM_ROUNDS must be in 1..32");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q,   key_d;
  logic [5:0]          cnt_q,   cnt_d;

  // PRESENT 4-bit S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // One key-register update for round counter i: rotate left by 61, S-box the
  // top nibble (top two nibbles for 128-bit keys), XOR i into the counter field.
  function automatic logic [KEY_SIZE-1:0] key_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0]          i);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox(r[KEY_SIZE-1 -: 4]);
    r[KEY_SIZE-5 -: 4] = (KEY_SIZE == 128) ? sbox(r[KEY_SIZE-5 -: 4]) : r[KEY_SIZE-5 -: 4];
    r[XOR_LO +: 5]     = r[XOR_LO +: 5] ^ i;
    return r;
  endfunction

  // Next-state logic: load on start from IDLE, advance on each handshake.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          cnt_d   = 6'd1;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          // The final key needs no successor, so no update is computed for it.
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            key_d = key_update(key_q, cnt_q[4:0]);
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, key register and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= {KEY_SIZE{1'b0}};
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_EMIT);
  assign rk_valid = (state_q == ST_EMIT);
  assign rk       = key_q[KEY_SIZE-1 -: 64];
  assign rk_idx   = cnt_q;
  assign rk_last  = (state_q == ST_EMIT) && (cnt_q == LAST_IDX);

endmodule

// File: doc/present_key_sched.md
PRESENT_KEY_SCHED -- requirements
Module: present_key_sched

Interface
REQ-001 The block SHALL have parameter KEY_SIZE, default 80, meaning PRESENT key width; only 80 and 128 are legal, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter NUM_ROUNDS, default 32, meaning the number of round keys emitted; legal range is 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a schedule from key_in.
REQ-006 The block SHALL have port key_in, input, KEY_SIZE bits: cipher master key, sampled on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: a schedule is in progress.
REQ-008 The block SHALL have port rk_valid, output, 1 bit: rk, rk_idx and rk_last are valid.
REQ-009 The block SHALL have port rk_ready, input, 1 bit: the consumer accepts the current round key.
REQ-010 The block SHALL have port rk, output, 64 bits: the current round key.
REQ-011 The block SHALL have port rk_idx, output, 6 bits: round key index, 1..NUM_ROUNDS.
REQ-012 The block SHALL have port rk_last, output, 1 bit: asserted with the round key whose index equals NUM_ROUNDS.

Function
REQ-013 The block SHALL be a two-state FSM: IDLE (busy=0, rk_valid=0) and EMIT (busy=1, rk_valid=1).
REQ-014 In IDLE, start=1 SHALL load the key register with key_in, set the round counter to 1, and enter EMIT on the next edge.
REQ-015 start SHALL be ignored while in EMIT; key_in changes during EMIT SHALL have no effect.
REQ-016 The output rk SHALL equal key_reg[KEY_SIZE-1:KEY_SIZE-64] combinationally from the register; rk_idx SHALL equal the round counter.
REQ-017 A handshake SHALL occur on an edge where rk_valid=1 and rk_ready=1; without a handshake, key_reg, rk, rk_idx and rk_last SHALL hold unchanged, with no limit on stall length.
REQ-018 On a handshake with counter i < NUM_ROUNDS, key_reg SHALL update in one cycle and the counter SHALL become i+1.
REQ-019 The KEY_SIZE=80 update SHALL be: rotate left 61; S-box applied to bits [79:76]; bits [19:15] XORed with i (5 bits).
REQ-020 The KEY_SIZE=128 update SHALL be: rotate left 61; S-box applied independently to bits [127:124] and [123:120]; bits [66:62] XORed with i (5 bits).
REQ-021 The S-box SHALL map input 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-022 On a handshake with counter i = NUM_ROUNDS, the FSM SHALL return to IDLE; rk_valid and busy SHALL drop on the next cycle.
REQ-023 A start asserted in the cycle of the final handshake SHALL be ignored; a new start SHALL be accepted only from IDLE.
REQ-024 With rk_ready held at 1, the block SHALL emit one key per cycle: first key 1 cycle after start, last key NUM_ROUNDS cycles after start.
REQ-025 With NUM_ROUNDS=1, a single key SHALL be emitted with rk_idx=1 and rk_last=1, and no key update SHALL be performed.

Reset
REQ-026 When rst=1, the block SHALL immediately (asynchronously) go to IDLE with busy=0, rk_valid=0, rk_last=0, rk=0, rk_idx=0, key_reg=0, and counter=0.
REQ-027 A reset asserted mid-schedule SHALL abort that schedule, with no further keys emitted; the first start after rst deasserts SHALL run a complete schedule from index 1.
REQ-028 start SHALL be ignored while rst=1.

Verification
REQ-029 The bench SHALL cover: KEY_SIZE=80, key_in=0, rk_ready=1 -> rk(1)=0000000000000000, rk(2)=C000000000000000, rk(3)=5000180000000001; 32 keys on consecutive cycles; rk_last only at index 32.
REQ-030 The bench SHALL cover: KEY_SIZE=128, key_in=0 -> rk(1)=0000000000000000, rk(2)=CC00000000000000; all 32 keys match the golden model.
REQ-031 The bench SHALL cover: random rk_ready stalls of 0..5 cycles, KEY_SIZE=80, random key -> outputs stable during each stall; key sequence identical to the no-stall run.
REQ-032 The bench SHALL cover: start pulsed at index 10 with a different key_in -> sequence unchanged; busy stays 1 until the index 32 handshake.
REQ-033 The bench SHALL cover: rst asserted at index 7 (asynchronous, mid-cycle) -> rk_valid=0 and busy=0 immediately; the next start yields index 1 with key_in[KEY_SIZE-1:KEY_SIZE-64].
REQ-034 The bench SHALL cover: NUM_ROUNDS=1 and NUM_ROUNDS=5 -> exactly 1 and 5 keys respectively, with rk_last on the final key, and the FSM back in IDLE one cycle after the final handshake.
